// File: rtl/sec_pkg.sv
// sec_pkg: shared types and constants for the keypad panel arbiter.
// Holds the FSM state enum, core_z bit positions and the disarm pattern.
package sec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SETX,
        TOGGLE,
        SETTLE,
        CHECK,
        RECOVER,
        DONE
    } state_t;

    // core_z status bit positions
    localparam int Z_ON   = 2;
    localparam int Z_LOCK = 1;
    localparam int Z_TRIG = 0;

    // Shifted MSB first after a triggered failure
    localparam logic [2:0] DISARM_PAT = 3'b010;

    // Extra core_u toggles after the code bits
    localparam int SETTLE_TOG = 2;

endpackage

// File: rtl/sec_rr_arb.sv
// sec_rr_arb: round-robin picker. Searches from ptr+1 upward, wrapping.
// Ports: req/mask (N) in, ptr (index of last winner) in, gnt one-hot out.
module sec_rr_arb #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    // Walk from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        int j;
        gnt = '0;
        j   = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[IW'(j)] && mask[IW'(j)]) begin
                gnt          = '0;
                gnt[IW'(j)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sec_panel_arb.sv
// sec_panel_arb: shares one serial lock core between N_PANELS keypads.
// Ports: clk, rst_n (async low); req/code per panel; arm_sw; core_z
//   status in; core_s/core_x/core_u core drive; grant one-hot; done
//   pulse with result_ok; alarm = registered core_z[0].
// Option: define SEC_ARB_LOCKOUT_EN to lock out a panel after three
//   consecutive failures for LOCKOUT_CYC cycles.
module sec_panel_arb
    import sec_pkg::*;
#(
    parameter int N_PANELS    = 4,
    parameter int CODE_W      = 4,
    parameter int LOCKOUT_CYC = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_PANELS-1:0]          req,
    input  logic [N_PANELS*CODE_W-1:0]   code,
    input  logic                         arm_sw,
    input  logic [2:0]                   core_z,
    output logic                         core_s,
    output logic                         core_x,
    output logic                         core_u,
    output logic [N_PANELS-1:0]          grant,
    output logic                         done,
    output logic                         result_ok,
    output logic                         alarm
);

    localparam int IW = (N_PANELS > 1) ? $clog2(N_PANELS) : 1;
    localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    state_t                state;
    state_t                nstate;
    logic [N_PANELS-1:0]   grant_q;
    logic [IW-1:0]         ptr;
    logic [CODE_W-1:0]     code_q;
    logic                  lock_ref;
    logic [BW-1:0]         bit_cnt;
    logic [2:0]            sub_cnt;
    logic [2:0]            dis_q;
    logic                  ok_q;

    logic [N_PANELS-1:0]   elig;
    logic [N_PANELS-1:0]   pick;
    logic [IW-1:0]         pick_idx;
    logic [CODE_W-1:0]     win_code;
    logic                  busy;
    logic                  abort;
    logic                  chk_ok;
    logic                  u_flip;
    logic                  x_set;
    logic                  x_val;
    logic                  core_on_unused;

    assign core_on_unused = core_z[Z_ON];

    sec_rr_arb #(
        .N  (N_PANELS),
        .IW (IW)
    ) u_rr (
        .req  (req),
        .mask (elig),
        .ptr  (ptr),
        .gnt  (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_PANELS; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    always_comb begin
        win_code = '0;
        for (int i = 0; i < N_PANELS; i++) begin
            if (grant_q[i]) win_code = win_code | code[i*CODE_W +: CODE_W];
        end
    end

    assign grant     = grant_q;
    assign done      = (state == DONE);
    assign result_ok = done & ok_q;

    assign busy   = (state != IDLE) && (state != DONE);
    assign abort  = busy && !arm_sw;
    assign chk_ok = (core_z[Z_LOCK] != lock_ref) && !core_z[Z_TRIG];

    always_comb begin
        nstate = state;
        u_flip = 1'b0;
        x_set  = 1'b0;
        x_val  = 1'b0;
        unique case (state)
            IDLE: begin
                if (core_s && (pick != '0)) nstate = GRANT;
            end
            GRANT: begin
                nstate = SETX;
            end
            // core_u high/low window brackets a stable core_x bit
            SETX: begin
                x_set  = 1'b1;
                x_val  = code_q[CODE_W-1];
                u_flip = 1'b1;
                nstate = TOGGLE;
            end
            TOGGLE: begin
                u_flip = 1'b1;
                nstate = (bit_cnt == BW'(CODE_W-1)) ? SETTLE : SETX;
            end
            SETTLE: begin
                x_set  = 1'b1;
                u_flip = 1'b1;
                if (sub_cnt == 3'(SETTLE_TOG-1)) nstate = CHECK;
            end
            CHECK: begin
                if (!chk_ok && core_z[Z_TRIG]) nstate = RECOVER;
                else                            nstate = DONE;
            end
            // steps 0..5: disarm bits as SETX/TOGGLE pairs; 6: settle
            RECOVER: begin
                u_flip = 1'b1;
                if (sub_cnt == 3'd6) begin
                    x_set  = 1'b1;
                    nstate = DONE;
                end else if (!sub_cnt[0]) begin
                    x_set = 1'b1;
                    x_val = dis_q[2];
                end
            end
            DONE: begin
                x_set  = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
        if (abort) begin
            nstate = DONE;
            u_flip = 1'b0;
            x_set  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_q  <= '0;
            ptr      <= IW'(N_PANELS-1);
            code_q   <= '0;
            lock_ref <= 1'b0;
            bit_cnt  <= '0;
            sub_cnt  <= '0;
            dis_q    <= '0;
            ok_q     <= 1'b0;
            core_s   <= 1'b0;
            core_x   <= 1'b0;
            core_u   <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            state   <= nstate;
            core_s  <= arm_sw;
            alarm   <= core_z[Z_TRIG];
            sub_cnt <= (nstate == state) ? sub_cnt + 3'd1 : 3'd0;
            if (u_flip) core_u <= ~core_u;
            if (x_set)  core_x <= x_val;
            if (state == IDLE && nstate == GRANT) begin
                grant_q <= pick;
                ptr     <= pick_idx;
                ok_q    <= 1'b0;
            end
            if (state == GRANT) begin
                code_q   <= win_code;
                lock_ref <= core_z[Z_LOCK];
                bit_cnt  <= '0;
            end
            if (state == TOGGLE) begin
                code_q  <= code_q << 1;
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (state == CHECK) begin
                ok_q  <= chk_ok;
                dis_q <= DISARM_PAT;
            end
            if (state == RECOVER && sub_cnt[0]) dis_q <= dis_q << 1;
            if (abort)         ok_q    <= 1'b0;
            if (state == DONE) grant_q <= '0;
        end
    end

`ifdef SEC_ARB_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_CYC + 1);

    logic [1:0]    fails [N_PANELS];
    logic [LW-1:0] lk    [N_PANELS];

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_PANELS; i++) begin
            elig[i] = (lk[i] == '0);
        end
    end

    // A locked panel cannot own the core, so the timer and the
    // result bookkeeping never act on the same panel together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PANELS; i++) begin
                fails[i] <= '0;
                lk[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < N_PANELS; i++) begin
                if (lk[i] != '0) begin
                    lk[i] <= lk[i] - LW'(1);
                    if (lk[i] == LW'(1)) fails[i] <= '0;
                end else if (done && grant_q[i]) begin
                    if (ok_q) begin
                        fails[i] <= '0;
                    end else if (fails[i] == 2'd2) begin
                        fails[i] <= 2'd3;
                        lk[i]    <= LW'(LOCKOUT_CYC);
                    end else begin
                        fails[i] <= fails[i] + 2'd1;
                    end
                end
            end
        end
    end
`else
    localparam int LOCKOUT_UNUSED = LOCKOUT_CYC;

    assign elig = '1;
`endif

endmodule
